// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Define CLA_SAT_EN to saturate the sum to the signed limit on overflow.
module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / BLOCK;

  function automatic logic grp_gen(input logic [BLOCK-1:0] gv, input logic [BLOCK-1:0] pv);
    logic r;
    r = 1'b0;
    for (int j = 0; j < BLOCK; j++) r = gv[j] | (pv[j] & r);
    return r;
  endfunction

  function automatic logic [NG:0] group_carries(input logic [NG-1:0] gv, input logic [NG-1:0] pv,
                                                input logic ci);
    logic [NG:0] c;
    logic        t;
    c = '0;
    for (int k = 0; k <= NG; k++) begin
      t = ci;
      for (int j = 0; j < k; j++) t = t & pv[j];
      c[k] = t;
      for (int j = 0; j < k; j++) begin
        t = gv[j];
        for (int m = j + 1; m < k; m++) t = t & pv[m];
        c[k] = c[k] | t;
      end
    end
    return c;
  endfunction

  function automatic logic [BLOCK:0] bit_carries(input logic [BLOCK-1:0] gv, input logic [BLOCK-1:0] pv,
                                                 input logic ci);
    logic [BLOCK:0] c;
    logic           t;
    c = '0;
    for (int k = 0; k <= BLOCK; k++) begin
      t = ci;
      for (int j = 0; j < k; j++) t = t & pv[j];
      c[k] = t;
      for (int j = 0; j < k; j++) begin
        t = gv[j];
        for (int m = j + 1; m < k; m++) t = t & pv[m];
        c[k] = c[k] | t;
      end
    end
    return c;
  endfunction

  logic [WIDTH-1:0] b_eff_s, p_s, g_s;
  logic             c0_s;
  logic [NG-1:0]    gg_s, gp_s;

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_p_r, s1_g_r;
  logic [NG-1:0]    s1_gg_r, s1_gp_r;
  logic             s1_c0_r, s1_a_msb_r, s1_b_msb_r;

  logic [NG:0]      gc_s;
  logic [BLOCK:0]   bc_s;
  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] sum_raw_s, sum_s;
  logic             ovf_s;

  logic             out_valid_r, cout_r, ovf_r;
  logic [WIDTH-1:0] sum_r;
  logic             out_adv_s, s1_adv_s;

  assign out_adv_s = !out_valid_r || out_ready;
  assign s1_adv_s  = !s1_valid_r || out_adv_s;
  assign in_ready  = s1_adv_s;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

  // Stage 1: operand conditioning, per-bit and per-group generate/propagate.
  always_comb begin
    b_eff_s = sub ? ~b : b;
    c0_s    = sub ? 1'b1 : cin;
    g_s     = a & b_eff_s;
    p_s     = a ^ b_eff_s;
    gg_s    = '0;
    gp_s    = '0;
    for (int k = 0; k < NG; k++) begin
      gg_s[k] = grp_gen(g_s[k*BLOCK +: BLOCK], p_s[k*BLOCK +: BLOCK]);
      gp_s[k] = &p_s[k*BLOCK +: BLOCK];
    end
  end

  // Stage 1 register: loads a new beat (or a bubble) whenever it may advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_p_r     <= '0;
      s1_g_r     <= '0;
      s1_gg_r    <= '0;
      s1_gp_r    <= '0;
      s1_c0_r    <= 1'b0;
      s1_a_msb_r <= 1'b0;
      s1_b_msb_r <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_p_r     <= p_s;
        s1_g_r     <= g_s;
        s1_gg_r    <= gg_s;
        s1_gp_r    <= gp_s;
        s1_c0_r    <= c0_s;
        s1_a_msb_r <= a[WIDTH-1];
        s1_b_msb_r <= b_eff_s[WIDTH-1];
      end
    end
  end

  // Stage 2: group-level then bit-level lookahead, sum and flags.
  always_comb begin
    gc_s = group_carries(s1_gg_r, s1_gp_r, s1_c0_r);
    c_s  = '0;
    bc_s = '0;
    for (int k = 0; k < NG; k++) begin
      bc_s = bit_carries(s1_g_r[k*BLOCK +: BLOCK], s1_p_r[k*BLOCK +: BLOCK], gc_s[k]);
      c_s[k*BLOCK +: BLOCK] = bc_s[BLOCK-1:0];
    end
    c_s[WIDTH] = gc_s[NG];
    sum_raw_s  = s1_p_r ^ c_s[WIDTH-1:0];
    ovf_s      = (s1_a_msb_r == s1_b_msb_r) && (sum_raw_s[WIDTH-1] != s1_a_msb_r);
`ifdef CLA_SAT_EN
    if (ovf_s) begin
      sum_s = s1_a_msb_r ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum_s = sum_raw_s;
    end
`else
    sum_s = sum_raw_s;
`endif
  end

  // Output register: holds its beat while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (out_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        sum_r  <= sum_s;
        cout_r <= c_s[WIDTH];
        ovf_r  <= ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe: 16/4 directed plus 32/8 and 8/4 instances in a random sweep.
module tb_cla_adder_pipe;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready, cin, sub;
  logic [31:0] a32, b32;

  logic in_ready32, out_valid32, cout32, ovf32;
  logic in_ready16, out_valid16, cout16, ovf16;
  logic in_ready8, out_valid8, cout8, ovf8;
  logic [31:0] sum32;
  logic [15:0] sum16;
  logic [7:0]  sum8;

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;
  int pop_cnt = 0;

  typedef struct {
    logic [33:0] r32;
    logic [33:0] r16;
    logic [33:0] r8;
    int          enq;
    logic        lat;
  } exp_t;

  exp_t q[$];
  logic        dir_en = 1'b0;
  logic [33:0] dir_r16 = 34'd0;

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(32), .BLOCK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .a(a32), .b(b32),
    .cin(cin), .sub(sub), .out_valid(out_valid32), .out_ready(out_ready), .sum(sum32),
    .cout(cout32), .ovf(ovf32));

  cla_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .a(a32[15:0]), .b(b32[15:0]),
    .cin(cin), .sub(sub), .out_valid(out_valid16), .out_ready(out_ready), .sum(sum16),
    .cout(cout16), .ovf(ovf16));

  cla_adder_pipe #(.WIDTH(8), .BLOCK(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .a(a32[7:0]), .b(b32[7:0]),
    .cin(cin), .sub(sub), .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8),
    .cout(cout8), .ovf(ovf8));

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference result packed as {ovf, cout, sum} for a w-bit adder.
  function automatic logic [33:0] model(input int w, input logic [31:0] ia, input logic [31:0] ib,
                                        input logic icin, input logic isub);
    logic [32:0] full;
    logic [31:0] mask, be, s;
    logic        c, o, am, bm;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    be   = (isub ? ~ib : ib) & mask;
    full = {1'b0, ia & mask} + {1'b0, be} + {32'd0, (isub ? 1'b1 : icin)};
    s    = full[31:0] & mask;
    c    = full[w];
    am   = ia[w-1];
    bm   = be[w-1];
    o    = (am == bm) && (s[w-1] != am);
`ifdef CLA_SAT_EN
    if (o) s = am ? (32'd1 << (w - 1)) : (mask >> 1);
`endif
    return {o, c, s};
  endfunction

  task automatic cyc(input logic iv, input logic [31:0] ia, input logic [31:0] ib, input logic icin,
                     input logic isub, input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid = iv; a32 = ia; b32 = ib; cin = icin; sub = isub; out_ready = ordy;
    #1;
    if (out_valid16) begin
      if (q.size() == 0) begin
        chk("spurious_out", {33'd0, out_valid16}, 34'd0);
      end else if (out_ready) begin
        e = q.pop_front();
        pop_cnt++;
        chk("res32", {ovf32, cout32, sum32}, e.r32);
        chk("res16", {ovf16, cout16, 16'h0000, sum16}, e.r16);
        chk("res8", {ovf8, cout8, 24'h000000, sum8}, e.r8);
        chk("valid32_8", {32'd0, out_valid32, out_valid8}, 34'd3);
        if (e.lat) chk("latency", 34'(cycle_no - e.enq), 34'd2);
      end else begin
        chk("hold16", {ovf16, cout16, 16'h0000, sum16}, q[0].r16);
        chk("hold32", {ovf32, cout32, sum32}, q[0].r32);
      end
    end
    acc = iv && in_ready16;
    if (acc) begin
      e.r32 = model(32, ia, ib, icin, isub);
      e.r16 = dir_en ? dir_r16 : model(16, ia, ib, icin, isub);
      e.r8  = model(8, ia, ib, icin, isub);
      e.enq = cycle_no;
      e.lat = dir_en;
      q.push_back(e);
    end
    @(posedge clk);
    cycle_no++;
  endtask

  task automatic dir(input logic [15:0] ia, input logic [15:0] ib, input logic icin, input logic isub,
                     input logic [15:0] es, input logic ec, input logic eo);
    logic acc;
    dir_en  = 1'b1;
    dir_r16 = {eo, ec, 16'h0000, es};
    cyc(1'b1, {16'h0000, ia}, {16'h0000, ib}, icin, isub, 1'b1, acc);
    dir_en  = 1'b0;
    chk("dir_accept", {33'd0, acc}, 34'd1);
    repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    int   idx;
    int   base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a32 = 32'd0; b32 = 32'd0; cin = 1'b0; sub = 1'b0;
    #1;
    chk("reset_state", {15'd0, out_valid16, ovf16, cout16, sum16}, 34'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready32, in_ready16, in_ready8}, 34'd7);

    // Directed arithmetic cases on the 16-bit instance.
    dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    dir(16'h1234, 16'h0FED, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);
    dir(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    dir(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
`ifdef CLA_SAT_EN
    dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
    dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Backpressure: five beats offered against a stalled consumer.
    idx  = 0;
    base = pop_cnt;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b1, 32'h0001_1000 * (idx + 1), 32'h0000_0333 * (idx + 2), idx[0], idx[1], 1'b0, acc);
      if (acc) idx++;
    end
    #1;
    chk("bp_accepts", 34'(idx), 34'd2);
    chk("bp_in_ready", {31'd0, in_ready32, in_ready16, in_ready8}, 34'd0);
    for (int c = 0; c < 20; c++) begin
      if (idx < 5) begin
        cyc(1'b1, 32'h0001_1000 * (idx + 1), 32'h0000_0333 * (idx + 2), idx[0], idx[1], 1'b1, acc);
        if (acc) idx++;
      end else begin
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
      end
    end
    chk("bp_pops", 34'(pop_cnt - base), 34'd5);
    chk("bp_empty", 34'(q.size()), 34'd0);

    // Reset with two beats in flight.
    cyc(1'b1, 32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_out", {15'd0, out_valid16, ovf16, cout16, sum16}, 34'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_in_ready", {33'd0, in_ready16}, 34'd1);
    base = pop_cnt;
    repeat (6) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    chk("no_stale", 34'(pop_cnt - base), 34'd0);

    // Random sweep with random valid/ready toggling.
    for (int c = 0; c < 800; c++) begin
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
    end
    repeat (10) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    chk("drain_empty", 34'(q.size()), 34'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
